// File: rtl/visualizer_frame_sequencer.sv
// Frame-level controller for the linear visualizer: accepts a note frame, launches the
// visualizer, latches its per-bin result and serializes exactly LEDS pixels to the LED driver.
module visualizer_frame_sequencer #(
  parameter int unsigned BIN_QTY    = 12,
  parameter int unsigned LEDS       = 50,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned NOTE_W     = 8,
  parameter int unsigned CW         = $clog2(LEDS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIN_QTY-1:0][NOTE_W-1:0]  notes_in,
  input  logic                            notes_valid,
  output logic                            notes_ready,
  output logic [BIN_QTY-1:0][NOTE_W-1:0]  vis_notes,
  output logic                            vis_start,
  input  logic                            vis_data_v,
  input  logic [BIN_QTY-1:0][23:0]        vis_rgb,
  input  logic [BIN_QTY-1:0][CW-1:0]      vis_led_counts,
  output logic [23:0]                     pix_rgb,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic                            pix_last,
  output logic                            busy,
  output logic                            timeout_flag,
  output logic [15:0]                     frame_count
);

  localparam int unsigned LW  = CW + 1;
  localparam int unsigned BIW = $clog2(BIN_QTY + 1);
  localparam int unsigned HW  = $clog2(START_HOLD + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_STREAM, S_PAD} state_e;

  state_e                          state_q, state_d;
  logic                            notes_ready_q, notes_ready_d;
  logic                            busy_q, busy_d;
  logic [BIN_QTY-1:0][NOTE_W-1:0]  vis_notes_q, vis_notes_d;
  logic                            vis_start_q, vis_start_d;
  logic [HW-1:0]                   hold_q, hold_d;
  logic [TW-1:0]                   wait_q, wait_d;
  logic [BIN_QTY-1:0][23:0]        rgb_q, rgb_d;
  logic [BIN_QTY-1:0][CW-1:0]      cnt_q, cnt_d;
  logic [BIW-1:0]                  bin_q, bin_d;
  logic [CW-1:0]                   cib_q, cib_d;
  logic [LW-1:0]                   led_q, led_d;
  logic [23:0]                     pix_rgb_q, pix_rgb_d;
  logic                            pix_valid_q, pix_valid_d;
  logic                            pix_last_q, pix_last_d;
  logic                            tflag_q, tflag_d;
  logic [15:0]                     frames_q, frames_d;

  logic [23:0]                     cur_rgb;
  logic [CW-1:0]                   cur_cnt;
  logic                            xfer;
  logic                            adv;
  logic [LW-1:0]                   led_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      notes_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      vis_notes_q   <= '0;
      vis_start_q   <= 1'b0;
      hold_q        <= '0;
      wait_q        <= '0;
      rgb_q         <= '0;
      cnt_q         <= '0;
      bin_q         <= '0;
      cib_q         <= '0;
      led_q         <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      pix_last_q    <= 1'b0;
      tflag_q       <= 1'b0;
      frames_q      <= '0;
    end else begin
      state_q       <= state_d;
      notes_ready_q <= notes_ready_d;
      busy_q        <= busy_d;
      vis_notes_q   <= vis_notes_d;
      vis_start_q   <= vis_start_d;
      hold_q        <= hold_d;
      wait_q        <= wait_d;
      rgb_q         <= rgb_d;
      cnt_q         <= cnt_d;
      bin_q         <= bin_d;
      cib_q         <= cib_d;
      led_q         <= led_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      pix_last_q    <= pix_last_d;
      tflag_q       <= tflag_d;
      frames_q      <= frames_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vis_notes_d = vis_notes_q;
    vis_start_d = 1'b0;
    hold_d      = hold_q;
    wait_d      = wait_q;
    rgb_d       = rgb_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    cib_d       = cib_q;
    led_d       = led_q;
    pix_rgb_d   = pix_rgb_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    tflag_d     = tflag_q;
    frames_d    = frames_q;
    cur_rgb     = '0;
    cur_cnt     = '0;

    for (int unsigned b = 0; b < BIN_QTY; b++) begin
      if (bin_q == BIW'(b)) begin
        cur_rgb = rgb_q[b];
        cur_cnt = cnt_q[b];
      end
    end

    // The output slot advances when empty or when its pixel is taken this cycle.
    xfer    = pix_valid_q && pix_ready;
    adv     = !pix_valid_q || pix_ready;
    led_nxt = led_q + LW'(xfer);
    if (xfer) led_d = led_nxt;

    case (state_q)
      S_IDLE: begin
        if (notes_valid && notes_ready_q) begin
          vis_notes_d = notes_in;
          hold_d      = '0;
          vis_start_d = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (hold_q == HW'(START_HOLD - 1)) begin
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          hold_d      = hold_q + HW'(1);
          vis_start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (vis_data_v || wait_q == TW'(TIMEOUT - 1)) begin
          if (vis_data_v) begin
            rgb_d = vis_rgb;
            cnt_d = vis_led_counts;
          end else begin
            tflag_d = 1'b1;
            cnt_d   = '0;
          end
          bin_d   = '0;
          cib_d   = '0;
          led_d   = '0;
          state_d = S_STREAM;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_STREAM, S_PAD: begin
        if (adv) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          pix_rgb_d   = '0;
          if (xfer && pix_last_q) begin
            frames_d = frames_q + 16'd1;
            state_d  = S_IDLE;
          end else if (state_q == S_PAD) begin
            pix_valid_d = 1'b1;
            pix_last_d  = (led_nxt == LW'(LEDS - 1));
          end else if (bin_q == BIW'(BIN_QTY)) begin
            state_d = S_PAD;
          end else if (cib_q == cur_cnt) begin
            bin_d = bin_q + BIW'(1);
            cib_d = '0;
          end else begin
            pix_rgb_d   = cur_rgb;
            pix_valid_d = 1'b1;
            pix_last_d  = (led_nxt == LW'(LEDS - 1));
            cib_d       = cib_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    notes_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
  end

  assign notes_ready  = notes_ready_q;
  assign busy         = busy_q;
  assign vis_notes    = vis_notes_q;
  assign vis_start    = vis_start_q;
  assign pix_rgb      = pix_rgb_q;
  assign pix_valid    = pix_valid_q;
  assign pix_last     = pix_last_q;
  assign timeout_flag = tflag_q;
  assign frame_count  = frames_q;

endmodule

// File: tb/tb_visualizer_frame_sequencer.sv
// Self-checking bench for visualizer_frame_sequencer: table of frames with randomized
// contents, a list-based pixel model, and hand-written reset/timeout sequences.
module tb_visualizer_frame_sequencer;

  localparam int unsigned BIN_QTY    = 12;
  localparam int unsigned LEDS       = 50;
  localparam int unsigned START_HOLD = 2;
  localparam int unsigned TIMEOUT    = 1023;
  localparam int unsigned NOTE_W     = 8;
  localparam int unsigned CW         = $clog2(LEDS);
  localparam int          NV         = 10;

  logic                           clk = 1'b0;
  logic                           rst = 1'b0;
  logic [BIN_QTY-1:0][NOTE_W-1:0] notes_in = '0;
  logic                           notes_valid = 1'b0;
  logic                           notes_ready;
  logic [BIN_QTY-1:0][NOTE_W-1:0] vis_notes;
  logic                           vis_start;
  logic                           vis_data_v = 1'b0;
  logic [BIN_QTY-1:0][23:0]       vis_rgb = '0;
  logic [BIN_QTY-1:0][CW-1:0]     vis_led_counts = '0;
  logic [23:0]                    pix_rgb;
  logic                           pix_valid;
  logic                           pix_ready = 1'b1;
  logic                           pix_last;
  logic                           busy;
  logic                           timeout_flag;
  logic [15:0]                    frame_count;

  always #5 clk = ~clk;

  visualizer_frame_sequencer #(
    .BIN_QTY(BIN_QTY), .LEDS(LEDS), .START_HOLD(START_HOLD),
    .TIMEOUT(TIMEOUT), .NOTE_W(NOTE_W), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .notes_in(notes_in), .notes_valid(notes_valid), .notes_ready(notes_ready),
    .vis_notes(vis_notes), .vis_start(vis_start),
    .vis_data_v(vis_data_v), .vis_rgb(vis_rgb), .vis_led_counts(vis_led_counts),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .timeout_flag(timeout_flag), .frame_count(frame_count)
  );

  typedef struct {
    int                         delay;
    int                         duty;
    bit                         timeout;
    bit                         junk;
    logic [BIN_QTY-1:0][CW-1:0] counts;
    logic [BIN_QTY-1:0][23:0]   rgb;
    bit                         exp_tflag;
  } vec_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic        last;
  } pix_t;

  vec_t        tv[NV];
  pix_t        got[$];
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          duty = 100;
  int          exp_frames = 0;
  bit          last_tflag = 1'b0;
  logic        stall_q = 1'b0;
  logic [23:0] stall_rgb = '0;
  logic        stall_last = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1 pix_ready = (int'($urandom_range(99)) < duty);
  end

  // Records every pixel transfer and checks outputs hold steady while stalled.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q)
        check("stall_hold", {pix_valid, pix_last, pix_rgb}, {1'b1, stall_last, stall_rgb});
      if (pix_valid && pix_ready) got.push_back({pix_rgb, pix_last});
      stall_q    <= pix_valid && !pix_ready;
      stall_rgb  <= pix_rgb;
      stall_last <= pix_last;
    end
  end

  // Expected pixel list: bins in order, truncated at LEDS, padded with black.
  task automatic build_expect(input vec_t v);
    exp_q.delete();
    for (int b = 0; b < int'(BIN_QTY); b++) begin
      int n;
      n = v.timeout ? 0 : int'(v.counts[b]);
      for (int k = 0; k < n; k++)
        if (exp_q.size() < LEDS) exp_q.push_back(v.rgb[b]);
    end
    while (exp_q.size() < LEDS) exp_q.push_back(24'h000000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int id, input vec_t v);
    logic [BIN_QTY-1:0][NOTE_W-1:0] sent;
    int n;
    got.delete();
    build_expect(v);
    duty = v.duty;
    notes_in    = {$urandom, $urandom, $urandom};
    sent        = notes_in;
    notes_valid = 1'b1;
    n = 0;
    while (!notes_ready && n < 50) begin tick(); n++; end
    tick();
    notes_valid = 1'b0;
    notes_in    = '0;
    check($sformatf("f%0d_vis_notes", id), vis_notes, sent);
    check($sformatf("f%0d_busy_notes_ready", id), {busy, notes_ready}, 2'b10);
    if (v.junk) begin
      vis_data_v     = 1'b1;
      vis_rgb        = {12{24'hABCDEF}};
      vis_led_counts = {12{6'd3}};
    end
    n = 0;
    while (vis_start && n < 10) begin tick(); n++; end
    vis_data_v = 1'b0;
    check($sformatf("f%0d_start_len", id), n, START_HOLD);
    if (v.timeout) begin
      repeat (1000) tick();
      check($sformatf("f%0d_pre_timeout", id), {timeout_flag, busy, pix_valid},
            {last_tflag, 1'b1, 1'b0});
    end else begin
      repeat (v.delay - int'(START_HOLD)) tick();
      vis_rgb        = v.rgb;
      vis_led_counts = v.counts;
      vis_data_v     = 1'b1;
      tick();
      vis_data_v     = 1'b0;
      vis_rgb        = {12{24'h123456}};
      vis_led_counts = '1;
    end
    n = 0;
    while (got.size() < LEDS && n < 5000) begin tick(); n++; end
    repeat (20) tick();
    check($sformatf("f%0d_pixel_count", id), got.size(), LEDS);
    for (int i = 0; i < int'(LEDS); i++)
      if (i < got.size())
        check($sformatf("f%0d_pix%0d", id, i), {got[i].rgb, got[i].last},
              {exp_q[i], 1'(i == int'(LEDS) - 1)});
    exp_frames++;
    check($sformatf("f%0d_frame_count", id), frame_count, exp_frames);
    check($sformatf("f%0d_timeout_flag", id), timeout_flag, v.exp_tflag);
    check($sformatf("f%0d_idle", id), {busy, notes_ready, pix_valid}, 3'b010);
    last_tflag = v.exp_tflag;
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      tv[i].delay     = int'($urandom_range(40, 3));
      tv[i].duty      = int'($urandom_range(100, 30));
      tv[i].timeout   = 1'b0;
      tv[i].junk      = 1'b0;
      tv[i].exp_tflag = (i >= 3);
      for (int b = 0; b < int'(BIN_QTY); b++) begin
        tv[i].rgb[b]    = 24'($urandom);
        tv[i].counts[b] = (i == 8) ? CW'($urandom_range(63)) : CW'($urandom_range(8));
      end
    end
    tv[0].delay = 20; tv[0].duty = 100; tv[0].counts = '0; tv[0].rgb = '0;
    tv[0].counts[0] = 6'd4; tv[0].counts[1] = 6'd4;
    tv[0].rgb[0] = 24'hFF0000; tv[0].rgb[1] = 24'h00FF00;
    tv[1].delay = 20; tv[1].duty = 100; tv[1].counts = {12{6'd5}};
    tv[2] = tv[0]; tv[2].duty = 30;
    tv[3].timeout = 1'b1; tv[3].exp_tflag = 1'b1;
    tv[5].junk = 1'b1;

    // Reset held with a frame offered.
    notes_valid = 1'b1;
    notes_in    = {$urandom, $urandom, $urandom};
    repeat (5) tick();
    check("reset_outputs", {notes_ready, pix_valid, vis_start, busy, timeout_flag, pix_last},
          6'b100000);
    check("reset_frame_count", frame_count, 16'd0);
    check("reset_vis_notes", vis_notes, '0);
    check("reset_pix_rgb", pix_rgb, 24'h0);
    notes_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("post_reset_idle", {busy, vis_start, notes_ready}, 3'b001);

    for (int i = 0; i < NV; i++) run_frame(i, tv[i]);

    // Reset in the middle of streaming, then a fresh nominal frame.
    begin
      int n;
      got.delete();
      duty        = 100;
      notes_in    = {$urandom, $urandom, $urandom};
      notes_valid = 1'b1;
      tick();
      notes_valid = 1'b0;
      repeat (5) tick();
      vis_rgb        = tv[1].rgb;
      vis_led_counts = tv[1].counts;
      vis_data_v     = 1'b1;
      tick();
      vis_data_v = 1'b0;
      n = 0;
      while (got.size() < 10 && n < 200) begin tick(); n++; end
      check("midreset_reached_pix10", got.size(), 10);
      rst = 1'b0;
      tick();
      check("midreset_outputs", {pix_valid, busy, notes_ready, timeout_flag}, 4'b0010);
      check("midreset_frame_count", frame_count, 16'd0);
      rst = 1'b1;
      tick();
      exp_frames = 0;
      last_tflag = 1'b0;
      run_frame(99, tv[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
